// File: rtl/lm70_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : lm70_spi_reader
// Purpose  : Reads 16-bit frames from an LM70 over SPI and decodes temperature.
//            Define LM70_AVG_EN to report a running mean of the last 4 good frames.
// Revision : 1.0 - initial release
// ============================================================================
module lm70_spi_reader #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int IDLE_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [10:0] temp_raw,
    output logic [7:0]  temp_int,
    output logic        temp_neg,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(IDLE_GAP - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [3:0]  div_cnt;
    logic [4:0]  half_cnt;
    logic [15:0] shift_reg;
    logic        div_last;
    logic        sample_now;
    logic        sck_next;
    logic        cs_n_next;
    logic        frame_good;
    logic [10:0] new_raw;
    logic [7:0]  new_int;

    assign div_last   = (div_cnt == DIV_LAST);
    assign frame_good = (shift_reg[4:2] == 3'b111);
    assign busy       = (state != ST_IDLE);

    // The idle window between frames includes the IDLE cycle itself, so GAP
    // is one cycle shorter and chip select stays high for DONE + IDLE_GAP.
    always_comb begin
        next_state = state;
        sample_now = 1'b0;
        sck_next   = 1'b0;
        cs_n_next  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start || auto_en) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    next_state = ST_SHIFT;
                    sample_now = 1'b1;
                    sck_next   = 1'b1;
                end
            end
            ST_SHIFT: begin
                sck_next = spi_sck;
                if (div_last) begin
                    sck_next   = half_cnt[0];
                    sample_now = half_cnt[0] && (half_cnt != 5'd31);
                    if (half_cnt == 5'd31) begin
                        next_state = ST_DONE;
                        sck_next   = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                next_state = (IDLE_GAP == 1) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        cs_n_next = !((next_state == ST_SETUP) || (next_state == ST_SHIFT));
    end

`ifdef LM70_AVG_EN
    logic [10:0]        hist [4];
    logic               hist_full;
    logic [10:0]        h1;
    logic [10:0]        h2;
    logic [10:0]        h3;
    logic signed [12:0] avg_sum;

    // Until the first good frame, every history slot takes the new sample.
    always_comb begin
        h1 = hist_full ? hist[0] : shift_reg[15:5];
        h2 = hist_full ? hist[1] : shift_reg[15:5];
        h3 = hist_full ? hist[2] : shift_reg[15:5];
        avg_sum = $signed({{2{shift_reg[15]}}, shift_reg[15:5]})
                + $signed({{2{h1[10]}}, h1})
                + $signed({{2{h2[10]}}, h2})
                + $signed({{2{h3[10]}}, h3});
        new_raw = avg_sum[12:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= 11'd0;
            hist_full <= 1'b0;
        end else if (state == ST_DONE && frame_good) begin
            hist[0]   <= shift_reg[15:5];
            hist[1]   <= h1;
            hist[2]   <= h2;
            hist[3]   <= h3;
            hist_full <= 1'b1;
        end
    end
`else
    assign new_raw = shift_reg[15:5];
`endif

    always_comb begin
        new_int = {1'b0, new_raw[8:2]};
        if (new_raw[10])     new_int = 8'd0;
        else if (new_raw[9]) new_int = 8'd127;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            div_cnt   <= 4'd0;
            half_cnt  <= 5'd0;
            shift_reg <= 16'd0;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            temp_raw  <= 11'd0;
            temp_int  <= 8'd0;
            temp_neg  <= 1'b0;
        end else begin
            state     <= next_state;
            spi_cs_n  <= cs_n_next;
            spi_sck   <= sck_next;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= (state != next_state) ? 8'd0 : cnt + 8'd1;
            if (sample_now) shift_reg <= {shift_reg[14:0], spi_miso};
            if (state != ST_SHIFT) begin
                div_cnt  <= 4'd0;
                half_cnt <= 5'd0;
            end else if (div_last) begin
                div_cnt  <= 4'd0;
                half_cnt <= half_cnt + 5'd1;
            end else begin
                div_cnt  <= div_cnt + 4'd1;
            end
            if (state == ST_DONE) begin
                valid     <= 1'b1;
                frame_err <= !frame_good;
                if (frame_good) begin
                    temp_raw <= new_raw;
                    temp_int <= new_int;
                    temp_neg <= new_raw[10];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lm70_spi_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lm70_spi_reader
// Purpose  : Randomized self-checking bench for lm70_spi_reader with an LM70 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lm70_spi_reader;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int IDLE_GAP = 16;
    localparam int LATENCY  = 1 + CS_SETUP + 32 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n;
    logic        spi_sck;
    logic [10:0] temp_raw;
    logic [7:0]  temp_int;
    logic        temp_neg;
    logic        valid;
    logic        frame_err;
    logic        busy;

    lm70_spi_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .auto_en   (auto_en),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .temp_raw  (temp_raw),
        .temp_int  (temp_int),
        .temp_neg  (temp_neg),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] frame = 16'h0000;
    int          bit_i = 15;
    int          rises = 0;
    int          last_rises = 0;
    int          hi_run = 0;
    int          last_hi_run = 0;
    int          valid_cnt = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs_n = 1'b1;
    logic [10:0] m_raw = 11'd0;
    int          hist[$];

    // LM70 model: presents the next frame bit after each SCK rise, MSB first.
    always @(posedge clk) begin
        #1;
        if (spi_cs_n) begin
            hi_run++;
            bit_i = 15;
            if (!prev_cs_n) last_rises = rises;
        end else begin
            if (prev_cs_n) begin
                last_hi_run = hi_run;
                hi_run = 0;
                rises = 0;
            end
            if (spi_sck && !prev_sck) begin
                rises++;
                bit_i--;
            end
        end
        if (valid) valid_cnt++;
        prev_sck  = spi_sck;
        prev_cs_n = spi_cs_n;
        spi_miso  = (bit_i >= 0) ? frame[bit_i] : 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_int(input logic [10:0] r);
        int s;
        s = $signed(r);
        if (s < 0) return 0;
        if (s / 4 > 127) return 127;
        return s / 4;
    endfunction

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        f = 16'($urandom);
        if ($urandom_range(3) != 0) f[4:2] = 3'b111;
        return f;
    endfunction

    task automatic model_reset();
        m_raw = 11'd0;
        hist.delete();
    endtask

    task automatic model_frame(input logic [15:0] f, output logic err);
        int v;
`ifdef LM70_AVG_EN
        int sum;
`endif
        err = (f[4:2] != 3'b111);
        if (!err) begin
            v = $signed(f[15:5]);
`ifdef LM70_AVG_EN
            if (hist.size() == 0) repeat (4) hist.push_front(v);
            else begin
                hist.push_front(v);
                void'(hist.pop_back());
            end
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            m_raw = 11'(sum >>> 2);
`else
            m_raw = 11'(v);
`endif
        end
    endtask

    task automatic check_outputs(input string pfx, input logic exp_err);
        check_val({pfx, "_err"}, frame_err, exp_err);
        check_val({pfx, "_raw"}, temp_raw, m_raw);
        check_val({pfx, "_int"}, temp_int, exp_int(m_raw));
        check_val({pfx, "_neg"}, temp_neg, exp_int(m_raw) == 0 && $signed(m_raw) < 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_reached", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [15:0] f, input bit poke);
        int   lat;
        int   n;
        logic err;
        wait_idle();
        @(negedge clk);
        frame = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 2000) begin
            @(negedge clk);
            lat++;
            start = poke && (lat == 40 || lat == 100);
            if (lat == 10) check_val("busy_in_frame", busy, 1'b1);
        end
        start = 1'b0;
        check_val("latency", lat, LATENCY);
        check_val("valid", valid, 1'b1);
        model_frame(f, err);
        check_outputs("frame", err);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("valid_pulse", valid, 1'b0);
        if (poke) begin
            wait_idle();
            n = 0;
            repeat (10) begin
                @(negedge clk);
                if (busy) n++;
            end
            check_val("start_ignored", n, 0);
        end
    endtask

    initial begin
        int          n;
        int          vc;
        logic        err;
        logic [15:0] fr;

        repeat (3) @(negedge clk);
        check_val("rst_cs_n", spi_cs_n, 1'b1);
        check_val("rst_sck", spi_sck, 1'b0);
        check_val("rst_valid", valid, 1'b0);
        check_val("rst_err", frame_err, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_raw", temp_raw, 11'd0);
        check_val("rst_int", temp_int, 8'd0);
        check_val("rst_neg", temp_neg, 1'b0);
        rst = 1'b0;
        model_reset();

        run_frame(16'h0C9F, 1'b0);
        run_frame(16'hF39F, 1'b1);
        run_frame(16'h0C9F, 1'b0);
        run_frame(16'h0C83, 1'b0);
        check_val("err_hold_int", temp_int, 8'd25);
        run_frame(16'h7FFF, 1'b0);
        run_frame(16'h801F, 1'b0);
        for (int k = 0; k < 12; k++) run_frame(rand_frame(), 1'($urandom_range(1)));

        // Continuous mode, with stray start pulses and auto_en dropped mid-frame.
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            fr = rand_frame();
            frame = fr;
            if (k == 0) auto_en = 1'b1;
            n = 0;
            while (!valid && n < 400) begin
                @(negedge clk);
                n++;
                start = (n == 50);
                if (k == 3 && n == 60) auto_en = 1'b0;
            end
            start = 1'b0;
            check_val("auto_valid", valid, 1'b1);
            model_frame(fr, err);
            check_outputs("auto", err);
            check_val("auto_sck_rises", last_rises, 16);
            if (k > 0) check_val("auto_cs_high", last_hi_run, IDLE_GAP + 1);
            @(negedge clk);
        end
        vc = valid_cnt;
        wait_idle();
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) n++;
        end
        check_val("auto_stopped", n, 0);
        check_val("auto_no_extra_valid", valid_cnt, vc);

        // Reset at the eighth SCK rising edge aborts the frame.
        @(negedge clk);
        frame = 16'h7FFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(rises == 8 && !spi_cs_n) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("edge8_reached", rises, 8);
        vc = valid_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_cs_n", spi_cs_n, 1'b1);
        check_val("abort_sck", spi_sck, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_valid", valid, 1'b0);
        check_val("abort_raw", temp_raw, 11'd0);
        rst = 1'b0;
        model_reset();
        repeat (200) @(negedge clk);
        check_val("abort_no_valid", valid_cnt, vc);
        run_frame(16'h0D1F, 1'b0);
        run_frame(rand_frame(), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
